stage_mem: RTL

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem_pkg.sv | 27 ++
 rtl/stage_mem_if.sv | 25 ++
 rtl/stage_mem_load_ext.sv | 37 +++
 rtl/stage_mem.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding,
// load funct3 codes and bit positions inside the memory control word.
package stage_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_RW   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int MCR_MEMW = 5;
  localparam int MCR_MEMR = 4;

  // Memory is word addressed on the bus; lane selection uses the dropped bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface stage_mem_if;

  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Write_ready;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_valid;
  logic        Read_data_ready;

  modport master (
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_ready,
    input  Write_ready, Mem_Req_Ready, Read_data, Read_data_valid
  );

  modport slave (
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_ready,
    output Write_ready, Mem_Req_Ready, Read_data, Read_data_valid
  );

endinterface

// File: rtl/stage_mem_load_ext.sv
// Load-data lane selection and sign/zero extension, purely combinational.
module load_ext
  import stage_mem_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword, then extend according to funct3.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = i_data;
    case (i_lane)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      2'd3:    w_byte = i_data[31:24];
      default: w_byte = i_data[7:0];
    endcase
    w_half = i_lane[1] ? i_data[31:16] : i_data[15:0];
    case (i_f3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_data;
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: performs at most one load/store per instruction,
// stalls the execute stage while the bus is busy, and registers writeback results.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_I,
  input  logic            rst,
  input  logic            Done_I,
  input  logic [XLEN-1:0] PC_I,
  input  logic [5:0]      MCR,
  input  logic [XLEN-1:0] WDR,
  input  logic [XLEN-1:0] ASR,
  input  logic [4:0]      RAR,
  input  logic [2:0]      F3R,
  output logic            Feedback_Mem_Acc,
  stage_mem_if.master     mem,
  output logic            Done_O,
  output logic [XLEN-1:0] PC_O,
  output logic            RF_wen,
  output logic [4:0]      RF_waddr,
  output logic [XLEN-1:0] RF_wdata
);

  state_e          r_state;
  state_e          w_next;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] w_ext;
  logic            w_mem_w;
  logic            w_mem_r;
  logic            w_mem_op;
  logic            w_mem_write;
  logic            w_mem_read;
  logic            w_rd_ready;
  logic            w_busy;
  logic            r_done;
  logic [XLEN-1:0] r_pc;
  logic            r_wen;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;

  assign w_mem_w  = MCR[MCR_MEMW];
  assign w_mem_r  = MCR[MCR_MEMR];
  assign w_mem_op = w_mem_w | w_mem_r;

  // State register.
  always_ff @(posedge clk_I or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and bus strobes; each handshake input is only looked at in its own state.
  always_comb begin
    w_next      = r_state;
    w_mem_write = 1'b0;
    w_mem_read  = 1'b0;
    w_rd_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = Done_I & w_mem_op;
        if (Done_I && w_mem_w) begin
          w_next = ST_WR;
        end else if (Done_I && w_mem_r) begin
          w_next = ST_RD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WR: begin
        w_mem_write = 1'b1;
        w_busy      = 1'b1;
        w_next      = mem.Write_ready ? ST_DONE : ST_WR;
      end
      ST_RD: begin
        w_mem_read = 1'b1;
        w_busy     = 1'b1;
        w_next     = mem.Mem_Req_Ready ? ST_RW : ST_RD;
      end
      ST_RW: begin
        w_rd_ready = 1'b1;
        w_busy     = 1'b1;
        w_next     = mem.Read_data_valid ? ST_DONE : ST_RW;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign Feedback_Mem_Acc    = w_busy;
  assign mem.MemWrite        = w_mem_write;
  assign mem.MemRead         = w_mem_read;
  assign mem.Read_data_ready = w_rd_ready;
  // Execute-stage registers are frozen by the stall, so these stay stable per access.
  assign mem.Address         = word_align(ASR);
  assign mem.Write_data      = WDR;
  assign mem.Write_strb      = MCR[3:0];

  // Capture the returned word only when the read-data handshake completes.
  always_ff @(posedge clk_I or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'h0000_0000;
    end else if (r_state == ST_RW && mem.Read_data_valid) begin
      r_rdata <= mem.Read_data;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  load_ext u_load_ext (
    .i_data (r_rdata),
    .i_lane (ASR[1:0]),
    .i_f3   (F3R),
    .o_data (w_ext)
  );

  // Writeback register: pulses once per retired instruction, holds data otherwise.
  always_ff @(posedge clk_I or posedge rst) begin
    if (rst) begin
      r_done  <= 1'b0;
      r_pc    <= 32'h0000_0000;
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'h0000_0000;
    end else if (r_state == ST_IDLE && Done_I && !w_mem_op) begin
      r_done  <= 1'b1;
      r_pc    <= PC_I;
      r_wen   <= (RAR != 5'd0);
      r_waddr <= RAR;
      r_wdata <= ASR;
    end else if (r_state == ST_DONE) begin
      // MemW wins when both request bits are set, so that case retires as a store.
      r_done  <= 1'b1;
      r_pc    <= PC_I;
      r_wen   <= !w_mem_w && (RAR != 5'd0);
      r_waddr <= RAR;
      r_wdata <= w_mem_w ? r_wdata : w_ext;
    end else begin
      r_done  <= 1'b0;
      r_wen   <= 1'b0;
    end
  end

  assign Done_O   = r_done;
  assign PC_O     = r_pc;
  assign RF_wen   = r_wen;
  assign RF_waddr = r_waddr;
  assign RF_wdata = r_wdata;

endmodule
